// File: rtl/mem_access_sequencer.sv
// MEM-stage data-memory access sequencer: one valid/ready request plus one response per load/store.
// Optional request/response timeout enabled by defining MEM_SEQ_TIMEOUT_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; accept the MEM-stage load/store
// REQ   | request presented, waiting for i_dmem_req_ready
// RSP   | request accepted, waiting for i_dmem_rsp_valid
// DONE  | single release cycle: o_done, flags valid, pipeline advances

`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module mem_access_sequencer #(
    parameter int unsigned XLEN           = `XLEN_64b,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned W             = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_mem_req_m,
    input  logic         i_mem_wr_m,
    input  logic [2:0]   i_f3_m,
    input  logic [W-1:0] i_addr_m,
    input  logic [W-1:0] i_wdata_m,
    output logic         o_dmem_req_valid,
    input  logic         i_dmem_req_ready,
    output logic         o_dmem_we,
    output logic [1:0]   o_dmem_size,
    output logic [W-1:0] o_dmem_addr,
    output logic [W-1:0] o_dmem_wdata,
    input  logic         i_dmem_rsp_valid,
    input  logic [W-1:0] i_dmem_rsp_data,
    input  logic         i_dmem_rsp_err,
    output logic [W-1:0] o_rdata_m,
    output logic         o_pipe_hold,
    output logic         o_done,
    output logic         o_access_fault,
    output logic         o_misaligned
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]   state_q;
    logic [1:0]   state_d;

    logic         req_we_q;
    logic [1:0]   req_size_q;
    logic [W-1:0] req_addr_q;
    logic [W-1:0] req_wdata_q;
    logic [W-1:0] rdata_q;
    logic         fault_q;
    logic         misal_q;

    logic         misaligned_m;
    logic         tmo_hit;

    logic         unused_f3;
    assign unused_f3 = i_f3_m[2];

    always_comb begin
        misaligned_m = 1'b0;
        case (i_f3_m[1:0])
            2'd0:    misaligned_m = 1'b0;
            2'd1:    misaligned_m = i_addr_m[0];
            2'd2:    misaligned_m = |i_addr_m[1:0];
            default: misaligned_m = |i_addr_m[2:0];
        endcase
    end

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Down-counter loaded on request launch; the final REQ/RSP cycle is the one holding 1.
    logic [TMO_W-1:0] tmo_cnt_q;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES);
        end else if ((state_q == ST_REQ) || (state_q == ST_RSP)) begin
            if (tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
            end
        end
    end
`else
    logic [31:0] unused_tmo_cycles;
    assign unused_tmo_cycles = 32'(TIMEOUT_CYCLES);
    assign tmo_hit           = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_mem_req_m) begin
                    state_d = misaligned_m ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_dmem_req_ready) begin
                    state_d = ST_RSP;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_RSP: begin
                // A response in the REQ/ready cycle is never seen here: only RSP samples it.
                if (i_dmem_rsp_valid || tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            req_we_q    <= 1'b0;
            req_size_q  <= 2'd0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            misal_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (i_mem_req_m && !misaligned_m) begin
                        req_we_q    <= i_mem_wr_m;
                        req_size_q  <= i_f3_m[1:0];
                        req_addr_q  <= i_addr_m;
                        req_wdata_q <= i_wdata_m;
                    end
                    if (i_mem_req_m && misaligned_m) begin
                        misal_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!i_dmem_req_ready && tmo_hit) begin
                        fault_q <= 1'b1;
                    end
                end
                ST_RSP: begin
                    if (i_dmem_rsp_valid) begin
                        if (!req_we_q) begin
                            rdata_q <= i_dmem_rsp_data;
                        end
                        fault_q <= i_dmem_rsp_err;
                    end else if (tmo_hit) begin
                        fault_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    fault_q <= 1'b0;
                    misal_q <= 1'b0;
                end
                default: begin
                    fault_q <= 1'b0;
                    misal_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_dmem_req_valid = (state_q == ST_REQ);
    assign o_dmem_we        = req_we_q;
    assign o_dmem_size      = req_size_q;
    assign o_dmem_addr      = req_addr_q;
    assign o_dmem_wdata     = req_wdata_q;
    assign o_rdata_m        = rdata_q;
    assign o_done           = (state_q == ST_DONE);
    assign o_access_fault   = fault_q;
    assign o_misaligned     = misal_q;

    // Hold covers the IDLE cycle that sees the access so EX_MEM cannot overwrite it.
    assign o_pipe_hold = i_rst_n &
                         (((state_q == ST_IDLE) && i_mem_req_m) ||
                          (state_q == ST_REQ) || (state_q == ST_RSP));

`ifndef SYNTHESIS
    a_req_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_dmem_req_valid && !i_dmem_req_ready) |=>
            ($stable(o_dmem_addr) && $stable(o_dmem_wdata) &&
             $stable(o_dmem_we) && $stable(o_dmem_size)));

    a_done_pulse: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_done |=> !o_done);
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer; timeout scenario runs when MEM_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_mem_access_sequencer;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         mem_req_m;
    logic         mem_wr_m;
    logic [2:0]   f3_m;
    logic [W-1:0] addr_m;
    logic [W-1:0] wdata_m;
    logic         dmem_req_valid;
    logic         dmem_req_ready;
    logic         dmem_we;
    logic [1:0]   dmem_size;
    logic [W-1:0] dmem_addr;
    logic [W-1:0] dmem_wdata;
    logic         dmem_rsp_valid;
    logic [W-1:0] dmem_rsp_data;
    logic         dmem_rsp_err;
    logic [W-1:0] rdata_m;
    logic         pipe_hold;
    logic         done;
    logic         access_fault;
    logic         misaligned;

    int vectors;
    int miscompares;

    mem_access_sequencer #(
        .XLEN           (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_mem_req_m      (mem_req_m),
        .i_mem_wr_m       (mem_wr_m),
        .i_f3_m           (f3_m),
        .i_addr_m         (addr_m),
        .i_wdata_m        (wdata_m),
        .o_dmem_req_valid (dmem_req_valid),
        .i_dmem_req_ready (dmem_req_ready),
        .o_dmem_we        (dmem_we),
        .o_dmem_size      (dmem_size),
        .o_dmem_addr      (dmem_addr),
        .o_dmem_wdata     (dmem_wdata),
        .i_dmem_rsp_valid (dmem_rsp_valid),
        .i_dmem_rsp_data  (dmem_rsp_data),
        .i_dmem_rsp_err   (dmem_rsp_err),
        .o_rdata_m        (rdata_m),
        .o_pipe_hold      (pipe_hold),
        .o_done           (done),
        .o_access_fault   (access_fault),
        .o_misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_req_m      = 1'b0;
        mem_wr_m       = 1'b0;
        f3_m           = 3'd0;
        addr_m         = '0;
        wdata_m        = '0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_data  = '0;
        dmem_rsp_err   = 1'b0;
    endtask

    // {valid, hold, done, fault, misal}
    task automatic test_reset();
        vectors++;
        if ({dmem_req_valid, pipe_hold, done, access_fault, misaligned} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {dmem_req_valid, pipe_hold, done, access_fault, misaligned});
        end
        vectors++;
        if ({rdata_m, dmem_addr, dmem_wdata, dmem_we, dmem_size} !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: rdata %h addr %h wdata %h we %b size %h expected all 0",
                     rdata_m, dmem_addr, dmem_wdata, dmem_we, dmem_size);
        end
    endtask

    task automatic test_load();
        mem_req_m = 1'b1; mem_wr_m = 1'b0; f3_m = 3'd3; addr_m = 64'h1000;
        #1;
        vectors++;
        if ({dmem_req_valid, pipe_hold} !== 2'b01) begin
            miscompares++;
            $display("FAIL load_idle: valid/hold got %b expected 01", {dmem_req_valid, pipe_hold});
        end
        step();
        dmem_req_ready = 1'b1;
        vectors++;
        if ({dmem_req_valid, pipe_hold, dmem_we, dmem_size} !== 5'b11011 || dmem_addr !== 64'h1000) begin
            miscompares++;
            $display("FAIL load_req: valid/hold/we/size %b addr %h expected 11011 addr 1000",
                     {dmem_req_valid, pipe_hold, dmem_we, dmem_size}, dmem_addr);
        end
        step();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 64'hDEADBEEF;
        vectors++;
        if ({dmem_req_valid, pipe_hold, done} !== 3'b010) begin
            miscompares++;
            $display("FAIL load_rsp: valid/hold/done got %b expected 010", {dmem_req_valid, pipe_hold, done});
        end
        step();
        dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
        vectors++;
        if ({pipe_hold, done, access_fault, misaligned} !== 4'b0100 || rdata_m !== 64'hDEADBEEF) begin
            miscompares++;
            $display("FAIL load_done: hold/done/fault/mis %b rdata %h expected 0100 rdata deadbeef",
                     {pipe_hold, done, access_fault, misaligned}, rdata_m);
        end
        mem_req_m = 1'b0;
        step();
        vectors++;
        if ({pipe_hold, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL load_after: hold/done got %b expected 00", {pipe_hold, done});
        end
    endtask

    task automatic test_store_wait();
        mem_req_m = 1'b1; mem_wr_m = 1'b1; f3_m = 3'd2;
        addr_m = 64'h2004; wdata_m = 64'hCAFEF00D12345678;
        step();
        addr_m = 64'h9999; wdata_m = 64'h1111;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({dmem_req_valid, pipe_hold, dmem_we, dmem_size} !== 5'b11110 ||
                dmem_addr !== 64'h2004 || dmem_wdata !== 64'hCAFEF00D12345678) begin
                miscompares++;
                $display("FAIL store_wait%0d: flags %b addr %h wdata %h expected 11110 2004 cafef00d12345678",
                         i, {dmem_req_valid, pipe_hold, dmem_we, dmem_size}, dmem_addr, dmem_wdata);
            end
            step();
        end
        dmem_req_ready = 1'b1;
        vectors++;
        if (dmem_req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL store_ready: valid got %b expected 1", dmem_req_valid);
        end
        step();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 64'h5555AAAA5555AAAA;
        step();
        dmem_rsp_valid = 1'b0;
        vectors++;
        if ({pipe_hold, done, access_fault} !== 3'b010 || rdata_m !== 64'hDEADBEEF) begin
            miscompares++;
            $display("FAIL store_done: hold/done/fault %b rdata %h expected 010 rdata deadbeef",
                     {pipe_hold, done, access_fault}, rdata_m);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_misaligned();
        mem_req_m = 1'b1; mem_wr_m = 1'b0; f3_m = 3'd1; addr_m = 64'h1003;
        step();
        vectors++;
        if ({dmem_req_valid, pipe_hold, done, misaligned, access_fault} !== 5'b00110) begin
            miscompares++;
            $display("FAIL misaligned_done: valid/hold/done/mis/fault got %b expected 00110",
                     {dmem_req_valid, pipe_hold, done, misaligned, access_fault});
        end
        mem_req_m = 1'b0;
        step();
        vectors++;
        if ({done, misaligned, dmem_req_valid} !== 3'b000 || rdata_m !== 64'hDEADBEEF) begin
            miscompares++;
            $display("FAIL misaligned_after: done/mis/valid %b rdata %h expected 000 deadbeef",
                     {done, misaligned, dmem_req_valid}, rdata_m);
        end
        idle_inputs();
    endtask

    task automatic test_fault();
        mem_req_m = 1'b1; mem_wr_m = 1'b0; f3_m = 3'd0; addr_m = 64'h3001;
        step();
        // Response alongside ready must be ignored.
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_data = 64'h99;
        step();
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        vectors++;
        if ({pipe_hold, done, dmem_req_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL rsp_with_ready: hold/done/valid got %b expected 100", {pipe_hold, done, dmem_req_valid});
        end
        step();
        dmem_rsp_valid = 1'b1; dmem_rsp_err = 1'b1; dmem_rsp_data = 64'h77;
        step();
        dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0;
        vectors++;
        if ({done, access_fault, misaligned} !== 3'b110 || rdata_m !== 64'h77) begin
            miscompares++;
            $display("FAIL bus_error: done/fault/mis %b rdata %h expected 110 rdata 77",
                     {done, access_fault, misaligned}, rdata_m);
        end
        idle_inputs();
        step();
        vectors++;
        if ({done, access_fault} !== 2'b00) begin
            miscompares++;
            $display("FAIL bus_error_clear: done/fault got %b expected 00", {done, access_fault});
        end
    endtask

    task automatic test_back_to_back();
        mem_req_m = 1'b1; mem_wr_m = 1'b0; f3_m = 3'd3; addr_m = 64'h5008;
        step();
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rsp_data = 64'h0123456789ABCDEF;
        step();
        dmem_rsp_valid = 1'b0;
        vectors++;
        if (done !== 1'b1 || rdata_m !== 64'h0123456789ABCDEF) begin
            miscompares++;
            $display("FAIL b2b_load: done %b rdata %h expected 1 0123456789abcdef", done, rdata_m);
        end
        mem_wr_m = 1'b1; addr_m = 64'h5010; wdata_m = 64'hA5A5;
        step();
        vectors++;
        if ({pipe_hold, dmem_req_valid, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_idle: hold/valid/done got %b expected 100", {pipe_hold, dmem_req_valid, done});
        end
        step();
        dmem_req_ready = 1'b1;
        vectors++;
        if ({dmem_req_valid, dmem_we} !== 2'b11 || dmem_addr !== 64'h5010 || dmem_wdata !== 64'hA5A5) begin
            miscompares++;
            $display("FAIL b2b_store_req: valid/we %b addr %h wdata %h expected 11 5010 a5a5",
                     {dmem_req_valid, dmem_we}, dmem_addr, dmem_wdata);
        end
        step();
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rsp_data = 64'hFFFF;
        step();
        dmem_rsp_valid = 1'b0;
        vectors++;
        if (done !== 1'b1 || rdata_m !== 64'h0123456789ABCDEF) begin
            miscompares++;
            $display("FAIL b2b_store_done: done %b rdata %h expected 1 0123456789abcdef", done, rdata_m);
        end
        idle_inputs();
        step();
    endtask

`ifdef MEM_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        mem_req_m = 1'b1; mem_wr_m = 1'b0; f3_m = 3'd3; addr_m = 64'h4000;
        step();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({dmem_req_valid, pipe_hold, done} !== 3'b110) begin
                miscompares++;
                $display("FAIL timeout_wait%0d: valid/hold/done got %b expected 110",
                         i, {dmem_req_valid, pipe_hold, done});
            end
            step();
        end
        vectors++;
        if ({dmem_req_valid, pipe_hold, done, access_fault} !== 4'b0011 ||
            rdata_m !== 64'h0123456789ABCDEF) begin
            miscompares++;
            $display("FAIL timeout_done: valid/hold/done/fault %b rdata %h expected 0011 0123456789abcdef",
                     {dmem_req_valid, pipe_hold, done, access_fault}, rdata_m);
        end
        mem_req_m = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 64'hBAD;
        step();
        step();
        dmem_rsp_valid = 1'b0;
        vectors++;
        if ({done, access_fault} !== 2'b00 || rdata_m !== 64'h0123456789ABCDEF) begin
            miscompares++;
            $display("FAIL timeout_late_rsp: done/fault %b rdata %h expected 00 0123456789abcdef",
                     {done, access_fault}, rdata_m);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_reset_mid_access();
        mem_req_m = 1'b1; mem_wr_m = 1'b0; f3_m = 3'd3; addr_m = 64'h6000;
        step();
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pipe_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold_comb: hold got %b expected 0", pipe_hold);
        end
        step();
        rst_n = 1'b1;
        mem_req_m = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 64'hFEEDFACE;
        #1;
        test_reset();
        step();
        dmem_rsp_valid = 1'b0;
        vectors++;
        if ({done, pipe_hold, access_fault} !== 3'b000 || rdata_m !== '0) begin
            miscompares++;
            $display("FAIL stray_rsp: done/hold/fault %b rdata %h expected 000 rdata 0",
                     {done, pipe_hold, access_fault}, rdata_m);
        end
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle_inputs();
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_load();
        test_store_wait();
        test_misaligned();
        test_fault();
        test_back_to_back();
`ifdef MEM_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_access();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
